// File: rtl/video_memory_render_if.sv
// Pixel-side bus of the console text renderer: scan address and RAM data in,
// cell coordinates, RAM index, pixel colours and cursor/arrow flags out.
interface video_memory_render_if;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic [12:0] roll_cnt;
    logic [7:0]  showASCII;
    logic [7:0]  scanCode_E0;
    logic [23:0] color_background;
    logic [23:0] color_text;
    logic [7:0]  keysX;
    logic [7:0]  keysY;
    logic [7:0]  offsetX;
    logic [7:0]  offsetY;
    logic [12:0] keys_index;
    logic [23:0] showcolor;
    logic [23:0] showcolor_header;
    logic        direction_flag;
    logic        cursor_en;

    modport master (
        output h_addr, v_addr, roll_cnt, showASCII, scanCode_E0, color_background, color_text,
        input  keysX, keysY, offsetX, offsetY, keys_index, showcolor, showcolor_header,
               direction_flag, cursor_en
    );

    modport slave (
        input  h_addr, v_addr, roll_cnt, showASCII, scanCode_E0, color_background, color_text,
        output keysX, keysY, offsetX, offsetY, keys_index, showcolor, showcolor_header,
               direction_flag, cursor_en
    );
endinterface

// File: rtl/video_memory_render.sv
// Text renderer for the 70-column console: scan address -> cell, RAM index, glyph pixel colour.
// Optional macro VM_CURSOR_BLINK_EN enables the cursor blink counter; otherwise cursor_en is 1 out of reset.
module video_memory_render #(
    parameter int          COLS         = 70,
    parameter int          CHAR_W       = 9,
    parameter int          CHAR_H       = 16,
    parameter int          HEAD_LEN     = 9,
    parameter int          CLK_FREQ     = 50000000,
    parameter int          BLINK_HZ     = 2,
    parameter logic [23:0] HEADER_COLOR = 24'h00FF00
) (
    input logic                  clk,
    input logic                  rst_n,
    video_memory_render_if.slave vif
);

    if (CLK_FREQ < 2 * BLINK_HZ) begin : g_bad_blink_cfg
        $error("video_memory_render: CLK_FREQ too low for BLINK_HZ");
    end

    // Glyph rows 2..13 carry the character code xor the row number; 0x00..0x20 and 0x7F..0xFF are blank.
    function automatic logic [8:0] font_row(input logic [7:0] ch, input logic [3:0] row);
        logic [8:0] bits;
        if (ch <= 8'h20 || ch >= 8'h7F || row < 4'd2 || row > 4'd13) begin
            bits = 9'd0;
        end else begin
            bits = {1'b0, ch} ^ {5'd0, row};
        end
        return bits;
    endfunction

    function automatic logic [7:0] prompt_char(input logic [7:0] idx);
        logic [7:0] ch;
        case (idx)
            8'd0:    ch = 8'h73; // s
            8'd1:    ch = 8'h79; // y
            8'd2:    ch = 8'h73; // s
            8'd3:    ch = 8'h40; // @
            8'd4:    ch = 8'h62; // b
            8'd5:    ch = 8'h61; // a
            8'd6:    ch = 8'h73; // s
            8'd7:    ch = 8'h68; // h
            8'd8:    ch = 8'h24; // $
            default: ch = 8'h00;
        endcase
        return ch;
    endfunction

    logic [9:0] hq_s, vq_s;
    logic [7:0] keysX_d, keysY_d, keysX_q, keysY_q;
    logic [3:0] offsetX_d, offsetY_d, offsetX_q, offsetY_q;
    logic [3:0] offx2_q;
    logic [8:0] glyph_q, hdr_glyph_q;
    logic       margin_q;
    logic       cursor_d, cursor_q;

    // Stage-1 next state: divide the scan address into cell and in-cell offset.
    always_comb begin
        hq_s      = vif.h_addr / 10'(CHAR_W);
        vq_s      = vif.v_addr / 10'(CHAR_H);
        keysX_d   = 8'(hq_s);
        keysY_d   = 8'(vq_s);
        offsetX_d = 4'(vif.h_addr - hq_s * 10'(CHAR_W));
        offsetY_d = 4'(vif.v_addr - vq_s * 10'(CHAR_H));
    end

    // Stage-1 cell/offset registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keysX_q   <= 8'd0;
            keysY_q   <= 8'd0;
            offsetX_q <= 4'd0;
            offsetY_q <= 4'd0;
        end else begin
            keysX_q   <= keysX_d;
            keysY_q   <= keysY_d;
            offsetX_q <= offsetX_d;
            offsetY_q <= offsetY_d;
        end
    end

    // Stage-2: both font ROM ports read synchronously, column offset and margin flag travel alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glyph_q     <= 9'd0;
            hdr_glyph_q <= 9'd0;
            offx2_q     <= 4'd0;
            margin_q    <= 1'b0;
        end else begin
            glyph_q     <= font_row(vif.showASCII, offsetY_q);
            hdr_glyph_q <= (keysX_q < 8'(HEAD_LEN)) ? font_row(prompt_char(keysX_q), offsetY_q) : 9'd0;
            offx2_q     <= offsetX_q;
            margin_q    <= (keysX_q >= 8'(COLS));
        end
    end

`ifdef VM_CURSOR_BLINK_EN
    localparam int HALF = CLK_FREQ / (2 * BLINK_HZ);
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] blink_cnt_d, blink_cnt_q;

    // Blink counter next state: wrap at the half period and flip the cursor phase.
    always_comb begin
        if (blink_cnt_q == CW'(HALF - 1)) begin
            blink_cnt_d = {CW{1'b0}};
            cursor_d    = ~cursor_q;
        end else begin
            blink_cnt_d = blink_cnt_q + CW'(1);
            cursor_d    = cursor_q;
        end
    end

    // Blink counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= {CW{1'b0}};
        end else begin
            blink_cnt_q <= blink_cnt_d;
        end
    end
`else
    // Without blinking the cursor is simply on once out of reset.
    always_comb begin
        cursor_d = 1'b1;
    end
`endif

    // Cursor phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor_q <= 1'b0;
        end else begin
            cursor_q <= cursor_d;
        end
    end

    assign vif.keysX          = keysX_q;
    assign vif.keysY          = keysY_q;
    assign vif.offsetX        = {4'd0, offsetX_q};
    assign vif.offsetY        = {4'd0, offsetY_q};
    assign vif.keys_index     = vif.roll_cnt + 13'(keysY_q) * 13'(COLS) + 13'(keysX_q);
    assign vif.showcolor      = (!margin_q && glyph_q[offx2_q]) ? vif.color_text : vif.color_background;
    assign vif.showcolor_header = hdr_glyph_q[offx2_q] ? HEADER_COLOR : vif.color_background;
    assign vif.direction_flag = (vif.scanCode_E0 == 8'h75) || (vif.scanCode_E0 == 8'h72) ||
                                (vif.scanCode_E0 == 8'h6B) || (vif.scanCode_E0 == 8'h74);
    assign vif.cursor_en      = cursor_q;

endmodule

// File: tb/tb_video_memory_render.sv
// Randomized scoreboard bench for video_memory_render with a character-RAM model.
module tb_video_memory_render;
    localparam int          TB_CLK_FREQ = 40;
    localparam int          TB_HALF     = TB_CLK_FREQ / 4;
    localparam logic [23:0] HDR_COL     = 24'h00FF00;

    typedef struct {
        logic [7:0]  kx, ky, ox, oy;
        logic [12:0] idx;
    } s1_t;
    typedef struct {
        logic [23:0] col, hdr;
    } s2_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    video_memory_render_if vif();

    video_memory_render #(.CLK_FREQ(TB_CLK_FREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vif   (vif)
    );

    logic [7:0] ram [0:8191];
    assign vif.showASCII = ram[vif.keys_index];

    s1_t   s1_q[$];
    s2_t   s2_q[$];
    int    checks = 0;
    int    failures = 0;
    logic  issue = 1'b0;
    logic  p1, p2;
    logic  sweep = 1'b0;
    int    seen [0:2099];
    int    oob = 0;
    string prompt = "sys@bash$";

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference font: blank for codes <= 0x20 and >= 0x7F and outside rows 2..13, else code xor row.
    function automatic logic [8:0] glyph(input logic [7:0] c, input int r);
        if (c <= 8'h20 || c >= 8'h7F || r < 2 || r > 13) return 9'd0;
        return {1'b0, c} ^ 9'(r);
    endfunction

    task automatic drive(input int h, input int v);
        s1_t e1;
        s2_t e2;
        int kx, ky, ox, oy, idx;
        logic [8:0] g, gh;
        kx = h / 9; ky = v / 16; ox = h % 9; oy = v % 16;
        idx = (int'(vif.roll_cnt) + 70 * ky + kx) % 8192;
        g  = glyph(ram[idx], oy);
        gh = (kx < 9) ? glyph(8'(prompt[kx]), oy) : 9'd0;
        e1.kx = 8'(kx); e1.ky = 8'(ky); e1.ox = 8'(ox); e1.oy = 8'(oy); e1.idx = 13'(idx);
        e2.col = (kx < 70 && g[ox]) ? vif.color_text : vif.color_background;
        e2.hdr = gh[ox] ? HDR_COL : vif.color_background;
        s1_q.push_back(e1);
        s2_q.push_back(e2);
        vif.h_addr = 10'(h);
        vif.v_addr = 10'(v);
        issue = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        issue = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Tracks which cycles carry a response, one and two clocks after issue.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1 <= 1'b0;
            p2 <= 1'b0;
        end else begin
            p1 <= issue;
            p2 <= p1;
        end
    end

    // Monitor: pops the expected responses and compares on the falling edge.
    always @(negedge clk) begin
        s1_t e1;
        s2_t e2;
        if (p1) begin
            if (s1_q.size() == 0) begin
                chk("s1_queue_underflow", 32'd1, 32'd0);
            end else begin
                e1 = s1_q.pop_front();
                chk("keysX", 32'(vif.keysX), 32'(e1.kx));
                chk("keysY", 32'(vif.keysY), 32'(e1.ky));
                chk("offsetX", 32'(vif.offsetX), 32'(e1.ox));
                chk("offsetY", 32'(vif.offsetY), 32'(e1.oy));
                chk("keys_index", 32'(vif.keys_index), 32'(e1.idx));
                if (sweep) begin
                    if (vif.keys_index < 13'd2100) seen[vif.keys_index]++;
                    else oob++;
                end
            end
        end
        if (p2) begin
            if (s2_q.size() == 0) begin
                chk("s2_queue_underflow", 32'd1, 32'd0);
            end else begin
                e2 = s2_q.pop_front();
                chk("showcolor", 32'(vif.showcolor), 32'(e2.col));
                chk("showcolor_header", 32'(vif.showcolor_header), 32'(e2.hdr));
            end
        end
    end

    initial begin
        int bad;
        logic [7:0] codes [6];
        logic [7:0] sc;
        for (int i = 0; i < 8192; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 2100; i++) seen[i] = 0;
        vif.h_addr = 10'd0; vif.v_addr = 10'd0; vif.roll_cnt = 13'd0;
        vif.scanCode_E0 = 8'd0;
        vif.color_background = 24'h102030; vif.color_text = 24'hE0D0C0;

        // Reset state
        #1;
        chk("rst_keysX", 32'(vif.keysX), 32'd0);
        chk("rst_offsetY", 32'(vif.offsetY), 32'd0);
        chk("rst_showcolor", 32'(vif.showcolor), 32'h102030);
        chk("rst_header", 32'(vif.showcolor_header), 32'h102030);
        chk("rst_cursor", 32'(vif.cursor_en), 32'd0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
`ifdef VM_CURSOR_BLINK_EN
        repeat (TB_HALF - 1) @(posedge clk);
        #1 chk("cursor_before_toggle", 32'(vif.cursor_en), 32'd0);
        @(posedge clk); #1 chk("cursor_first_toggle", 32'(vif.cursor_en), 32'd1);
        repeat (TB_HALF) @(posedge clk);
        #1 chk("cursor_second_toggle", 32'(vif.cursor_en), 32'd0);
`else
        @(posedge clk); #1 chk("cursor_tied_high", 32'(vif.cursor_en), 32'd1);
        repeat (TB_HALF) @(posedge clk);
        #1 chk("cursor_stays_high", 32'(vif.cursor_en), 32'd1);
`endif

        // Directed cells
        vif.roll_cnt = 13'd140;
        ram[282] = 8'h41; ram[141] = 8'h41; ram[142] = 8'h20; ram[210] = 8'h41;
        drive(20, 35);
        drive(10, 3);
        drive(19, 5);
        drive(0, 0);
        drive(9, 0);
        drive(1, 5);
        drive(81, 5);
        drive(635, 3);
        drive(631, 4);
        idle(3);

        // Random bursts with per-burst scroll and colours
        for (int b = 0; b < 20; b++) begin
            vif.roll_cnt = 13'(70 * $urandom_range(0, 116));
            vif.color_background = 24'($urandom);
            vif.color_text = 24'($urandom);
            for (int i = 0; i < 40; i++) begin
                if (i % 4 == 0) drive($urandom_range(0, 80), $urandom_range(0, 47));
                else drive($urandom_range(0, 639), $urandom_range(0, 479));
            end
            idle(3);
        end

        // Cell sweep of the whole frame
        vif.roll_cnt = 13'd0;
        sweep = 1'b1;
        for (int ky = 0; ky < 30; ky++)
            for (int kx = 0; kx < 70; kx++)
                drive(9 * kx + (kx % 9), 16 * ky + (ky % 16));
        idle(3);
        sweep = 1'b0;
        bad = oob;
        for (int i = 0; i < 2100; i++) if (seen[i] != 1) bad++;
        chk("sweep_index_coverage", 32'(bad), 32'd0);

        // Arrow-key decode
        codes[0] = 8'h75; codes[1] = 8'h72; codes[2] = 8'h6B;
        codes[3] = 8'h74; codes[4] = 8'h5A; codes[5] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            vif.scanCode_E0 = codes[i];
            #1 chk("direction_flag", 32'(vif.direction_flag), (i < 4) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 20; i++) begin
            sc = 8'($urandom);
            vif.scanCode_E0 = sc;
            #1 chk("direction_flag_rand", 32'(vif.direction_flag),
                   (sc == 8'h75 || sc == 8'h72 || sc == 8'h6B || sc == 8'h74) ? 32'd1 : 32'd0);
        end

        // Reset in mid-frame
        vif.roll_cnt = 13'd0;
        vif.h_addr = 10'd600; vif.v_addr = 10'd400;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_keysX", 32'(vif.keysX), 32'd0);
        chk("midrst_keysY", 32'(vif.keysY), 32'd0);
        chk("midrst_offsetX", 32'(vif.offsetX), 32'd0);
        chk("midrst_keys_index", 32'(vif.keys_index), 32'd0);
        chk("midrst_showcolor", 32'(vif.showcolor), 32'(vif.color_background));
        chk("midrst_cursor", 32'(vif.cursor_en), 32'd0);
        if (s1_q.size() != 0 || s2_q.size() != 0) chk("queues_drained", 32'(s1_q.size() + s2_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
